// File: rtl/bp_pkg.sv
// Fixed-point constants, FSM state type and saturation helper shared by the
// backprop delta-out engine and its MAC.
package bp_pkg;

    localparam int DEF_WIDTH = 24;
    localparam int DEF_FRAC  = 20;

    localparam logic signed [DEF_WIDTH-1:0] ONE   = DEF_WIDTH'(1 << DEF_FRAC);
    localparam logic signed [DEF_WIDTH-1:0] W_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
    localparam logic signed [DEF_WIDTH-1:0] W_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // Clamp a sign-extended value into the signed range of out_width bits.
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] value,
                                                 input int unsigned out_width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_width - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/bp_dout_engine_mac_sat.sv
// Registered multiply-accumulate with floor-shifted products and an
// accumulator that saturates at its own WIDTH+GUARD bounds.
module mac_sat #(
    parameter int WIDTH = 24,
    parameter int FRAC  = 20,
    parameter int GUARD = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          first,
    input  logic                          valid,
    input  logic signed [WIDTH-1:0]       i_x,
    input  logic signed [WIDTH-1:0]       i_m,
    output logic signed [WIDTH+GUARD-1:0] o_acc,
    output logic                          o_sat_evt
);
    import bp_pkg::*;

    localparam int AW = WIDTH + GUARD;
    localparam int PW = 2 * WIDTH;

    logic signed [AW-1:0] acc_q, acc_d;
    logic                 sat_evt_q, sat_evt_d;
    logic signed [PW-1:0] prod_full, prod;
    logic signed [63:0]   sum_wide, sum_sat;

    // The first flag drops the old sum so consecutive outputs need no idle cycle.
    always_comb begin
        prod_full = i_x * i_m;
        prod      = prod_full >>> FRAC;
        sum_wide  = {{(64-PW){prod[PW-1]}}, prod}
                  + (first ? 64'sd0 : {{(64-AW){acc_q[AW-1]}}, acc_q});
        sum_sat   = sat_w(sum_wide, AW);
        acc_d     = acc_q;
        sat_evt_d = 1'b0;
        if (valid) begin
            acc_d     = sum_sat[AW-1:0];
            sat_evt_d = (sum_sat != sum_wide);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            sat_evt_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            sat_evt_q <= sat_evt_d;
        end
    end

    assign o_acc     = acc_q;
    assign o_sat_evt = sat_evt_q;

endmodule

// File: rtl/bp_dout_engine.sv
// LSTM backprop delta-out engine: dout[j] = sum over t of dgate[t] * W[j*T+t],
// sequenced over external memories and written back one result per j.
module bp_dout_engine #(
    parameter int WIDTH    = 24,
    parameter int FRAC     = 20,
    parameter int N_IN     = 53,
    parameter int N_CELL   = 8,
    parameter int NUM_GATE = 4,
    parameter int GUARD    = 6,
    parameter int ADDR_W   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    output logic [ADDR_W-1:0] o_dg_addr,
    input  logic [WIDTH-1:0]  i_dg_data,
    output logic [ADDR_W-1:0] o_w_addr,
    input  logic [WIDTH-1:0]  i_w_data,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [WIDTH-1:0]  o_wr_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_sat
);
    import bp_pkg::*;

    localparam int T  = NUM_GATE * N_CELL;
    localparam int AW = WIDTH + GUARD;
    localparam logic [ADDR_W-1:0] T_LAST = ADDR_W'(T - 1);
    localparam logic [ADDR_W-1:0] J_LAST = ADDR_W'(N_IN - 1);

    if (N_IN * T > 2 ** ADDR_W) begin : g_cfg_check
        $error("bp_dout_engine: N_IN*T does not fit in ADDR_W address bits");
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] t_q, t_d, j_q, j_d, wa_q, wa_d;
    logic              iss_valid_q, iss_valid_d, iss_first_q, iss_first_d, iss_last_q, iss_last_d;
    logic              d_valid_q, d_valid_d, d_first_q, d_first_d, d_last_q, d_last_d;
    logic [ADDR_W-1:0] d_j_q, d_j_d, wr_addr_q, wr_addr_d;
    logic              wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d, sat_q, sat_d;
    logic              abort_now, clamp_evt, mac_sat_evt;
    logic signed [AW-1:0] mac_acc;
    logic signed [63:0]   acc_wide, acc_clamped;

    mac_sat #(.WIDTH(WIDTH), .FRAC(FRAC), .GUARD(GUARD)) u_mac (
        .clk       (clk),
        .rst       (rst),
        .first     (d_first_q),
        .valid     (d_valid_q & ~abort_now),
        .i_x       (i_dg_data),
        .i_m       (i_w_data),
        .o_acc     (mac_acc),
        .o_sat_evt (mac_sat_evt)
    );

    always_comb begin
        acc_wide    = {{(64-AW){mac_acc[AW-1]}}, mac_acc};
        acc_clamped = sat_w(acc_wide, WIDTH);
        clamp_evt   = wr_en_q && (acc_clamped != acc_wide);
        abort_now   = i_abort && (state_q != IDLE);
    end

    // Issue stage flags travel one stage to line up with the returning read data.
    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        j_d         = j_q;
        wa_d        = wa_q;
        iss_valid_d = 1'b0;
        iss_first_d = 1'b0;
        iss_last_d  = 1'b0;
        d_valid_d   = iss_valid_q;
        d_first_d   = iss_first_q;
        d_last_d    = iss_last_q;
        d_j_d       = j_q;
        wr_en_d     = d_valid_q && d_last_q;
        wr_addr_d   = (d_valid_q && d_last_q) ? d_j_q : '0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sat_d       = sat_q | mac_sat_evt | clamp_evt;
        case (state_q)
            IDLE: begin
                if (i_start && !i_abort) begin
                    state_d     = RUN;
                    t_d         = '0;
                    j_d         = '0;
                    wa_d        = '0;
                    iss_valid_d = 1'b1;
                    iss_first_d = 1'b1;
                    iss_last_d  = (T_LAST == '0);
                    busy_d      = 1'b1;
                    sat_d       = 1'b0;
                end
            end
            RUN: begin
                if (t_q == T_LAST && j_q == J_LAST) begin
                    state_d = DRAIN;
                end else begin
                    iss_valid_d = 1'b1;
                    wa_d        = wa_q + 1'b1;
                    if (t_q == T_LAST) begin
                        t_d = '0;
                        j_d = j_q + 1'b1;
                    end else begin
                        t_d = t_q + 1'b1;
                    end
                    iss_first_d = (t_d == '0);
                    iss_last_d  = (t_d == T_LAST);
                end
            end
            DRAIN: begin
                if (wr_en_q && wr_addr_q == J_LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort_now) begin
            state_d     = IDLE;
            iss_valid_d = 1'b0;
            d_valid_d   = 1'b0;
            wr_en_d     = 1'b0;
            wr_addr_d   = '0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            t_q         <= '0;
            j_q         <= '0;
            wa_q        <= '0;
            iss_valid_q <= 1'b0;
            iss_first_q <= 1'b0;
            iss_last_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            d_first_q   <= 1'b0;
            d_last_q    <= 1'b0;
            d_j_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            j_q         <= j_d;
            wa_q        <= wa_d;
            iss_valid_q <= iss_valid_d;
            iss_first_q <= iss_first_d;
            iss_last_q  <= iss_last_d;
            d_valid_q   <= d_valid_d;
            d_first_q   <= d_first_d;
            d_last_q    <= d_last_d;
            d_j_q       <= d_j_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sat_q       <= sat_d;
        end
    end

    assign o_dg_addr = t_q;
    assign o_w_addr  = wa_q;
    assign o_wr_en   = wr_en_q;
    assign o_wr_addr = wr_addr_q;
    assign o_wr_data = wr_en_q ? acc_clamped[WIDTH-1:0] : '0;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_sat     = sat_q;

endmodule

// File: doc/bp_dout_engine.md
Name: bp_dout_engine

Overview:
- Parametrised LSTM backprop delta-out engine. Computes dout[j] = sum over g,k of dgate_g[k] * W_g[k][j] for every input/cell index j.
- Fixed-point arithmetic with guard-bit accumulation and output saturation.
- Sequences reads from an external dgate memory and weight memory, then writes each result to a dout/dX memory through a write port.
- Replaces the hand-wired single MAC and weight multiplexers of the backprop datapath. Any layer (dX of layer 2, dout of layer 1) is serviced by one instance per size.

Parameters:
- WIDTH, 24, data word width (signed fixed point).
- FRAC, 20, fractional bits.
- N_IN, 53, number of outputs j (input/cell count of the target vector).
- N_CELL, 8, cells k of the layer supplying dgate.
- NUM_GATE, 4, gates per cell (a,i,f,o order).
- GUARD, 6, extra integer bits in the accumulator.
- ADDR_W, 12, width of all address ports.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_start  in  1  begin a pass; sampled only in IDLE
- i_abort  in  1  synchronous abort of a pass
- o_dg_addr  out  ADDR_W  dgate read address, t = g*N_CELL + k
- i_dg_data  in  WIDTH  dgate read data, valid 1 cycle after address
- o_w_addr  out  ADDR_W  weight read address = j*T + t, where T = NUM_GATE*N_CELL
- i_w_data  in  WIDTH  weight read data, valid 1 cycle after address
- o_wr_en  out  1  result write strobe, one cycle per j
- o_wr_addr  out  ADDR_W  result address j
- o_wr_data  out  WIDTH  saturated result
- o_busy  out  1  pass in progress
- o_done  out  1  one-cycle pulse after the last write
- o_sat  out  1  sticky: any result or accumulation saturated since last start

Behaviour:
- Reset (async, rst high): state IDLE; all outputs 0; counters j, t cleared; accumulator 0; pipeline valid flags 0.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN: i_start high at an edge. o_sat clears at that edge; o_busy goes high the next cycle.
  - RUN: issues one address pair per cycle, no bubbles. t counts 0..T-1 and wraps; j increments on wrap. o_w_addr increments by 1 every cycle.
  - RUN -> DRAIN: after the address pair j=N_IN-1, t=T-1 is issued.
  - DRAIN -> IDLE: after the last write retires. o_done pulses in the cycle after the final o_wr_en. o_busy falls together with o_done.
- Timing: start sampled at the edge ending cycle 0. The first address of output j is presented in cycle A_j = 1 + j*T. o_wr_en for j is high in cycle A_j + T + 1, with o_wr_addr = j.
- Pipeline: the issue stage registers the valid, first and last flags alongside the addresses. These flags are re-aligned with the returning data one cycle later.
- Arithmetic:
  - prod = (dg * w) >>> FRAC. Arithmetic shift, floor rounding (truncation toward -inf).
  - acc_next = (first ? 0 : acc) + prod, held in WIDTH+GUARD bits. The accumulator saturates at its own bounds and sets o_sat.
  - On last: o_wr_data = acc_next clamped to [0x7FF..F, 0x800..0] at WIDTH bits; o_sat is set if the clamp engaged.
- Back-to-back outputs: the first flag restarts accumulation with no idle cycle. A write for j and the first accumulate for j+1 may share a cycle.
- i_start while o_busy is high: ignored.
- i_abort high at an edge in RUN or DRAIN: return to IDLE; flush the pipeline; no further o_wr_en; no o_done. In IDLE it has no effect. i_abort wins over a simultaneous i_start.
- rst mid-pass: immediate return to reset state; a pending write is lost.
- Address counters never exceed N_IN*T-1. The elaboration check requires N_IN*T <= 2^ADDR_W.

Decomposition:
- Package bp_pkg holds:
  - fixed-point localparams (ONE = 1<<FRAC, MAX/MIN per width);
  - the FSM state enum;
  - a saturating-clamp function sat_w(value, out_width).
- Sub-module mac_sat: registered saturating MAC with ports first, valid, i_x, i_m, o_acc, o_sat_evt. The top holds the FSM, counters and flag pipeline.

Test Plan:
All cases use WIDTH=24, FRAC=20, N_IN=2, N_CELL=2, NUM_GATE=2 (T=4) unless stated otherwise.
- Nominal: all dgate=0x080000 (0.5), all w=0x040000 (0.25), start in cycle 0 -> o_wr_en in cycles 6 and 10, addr 0 then 1, data 0x080000 both; o_done in cycle 11; o_sat=0; o_w_addr sweeps 0..7 over cycles 1..8.
- Saturation: dgate=w=0x7FFFFF -> data 0x7FFFFF, o_sat=1. Same run with w=0x800000 -> data 0x800000.
- Rounding: one term dg=0x000001, w=0x080000, other terms 0 -> 0x000000. With dg=0xFFFFFF -> 0xFFFFFF (floor).
- Abort: assert i_abort in cycle 7 -> only the j=0 write (cycle 6) occurs; no o_done; o_busy=0 in cycle 8; a new start then runs normally.
- Start while busy: pulse i_start in cycle 3 -> ignored, timing identical to nominal.
- Async reset: rst in cycle 5 mid-pass -> all outputs 0 immediately, no writes; a restart gives nominal results. Repeat nominal at default parameters against a model for 53 outputs.
